// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package sw_pkg;

  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int unsigned DEBOUNCE_SIM         = 4;

  // Counter width able to hold 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-bit debouncer: 2-flop synchronizer, stability counter, edge pulses.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned         CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;

  // Only r_s2 feeds the counter; the raw pin never reaches other logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= sw_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_clean <= r_s2;
        r_cnt   <= '0;
        r_rise  <= r_s2;
        r_fall  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sw_clean = r_clean;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;

endmodule

// File: rtl/switch_debounce.sv
// Multi-bit switch debouncer: one independent debounce_bit per switch.
module switch_debounce
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .sw_raw  (sw_raw[g]),
      .sw_clean(sw_clean[g]),
      .sw_rise (sw_rise[g]),
      .sw_fall (sw_fall[g])
    );
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input conditioner for board slide switches and push-buttons.
- Each raw, asynchronous switch bit passes through a 2-flop synchronizer and a stability counter.
- Outputs are a clean level per bit plus one-cycle rise and fall pulses.
- Sits between the board pins and the combinational gate logic and LED drivers, so downstream logic only ever sees glitch-free, clock-aligned switch values.

Parameters:
- WIDTH, 2: number of independent switch bits.
- STABLE_CYCLES, 1000000: consecutive cycles a new synchronized value must hold before it is accepted (10 ms at 100 MHz). Legal range is 1 or more.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk
- sw_clean  output  WIDTH  debounced level per bit
- sw_rise  output  WIDTH  one-cycle pulse when the matching sw_clean bit goes 0->1
- sw_fall  output  WIDTH  one-cycle pulse when the matching sw_clean bit goes 1->0

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- While reset is asserted, all of the following are 0:
  - synchronizer flops
  - counters
  - sw_clean, sw_rise, sw_fall
- Bits are fully independent. Per bit:
  - s1 <= sw_raw[i]; s2 <= s1.
  - s2 is the only signal used downstream. sw_raw never reaches any other logic.
- Counter cnt has width $clog2(STABLE_CYCLES+1). On each edge:
  - If s2 == sw_clean[i]: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: sw_clean[i] <= s2; cnt <= 0; the matching pulse is asserted.
  - Else: cnt <= cnt + 1.
- Latency: edge N is the first edge to sample a new stable sw_raw value. sw_clean changes on edge N+STABLE_CYCLES+1, provided sw_raw stays constant throughout.
- Pulses:
  - sw_rise and sw_fall are registered.
  - Each is high for exactly the one cycle following the edge on which sw_clean changed. They are 0 on every other cycle.
  - sw_rise[i] and sw_fall[i] are never high together.
- Bounce: any return of s2 to the sw_clean value before the count completes clears cnt to 0. No output change and no pulse occur. A glitch shorter than STABLE_CYCLES cycles is fully rejected.
- Simultaneous events: several bits may update on the same edge. Each bit asserts its own pulse independently, in the same cycle.
- Counter wrap: cnt never exceeds STABLE_CYCLES-1, so no overflow is possible.
- Reset mid-count: the count is discarded and sw_clean returns to 0. After reset deasserts, a switch held high is treated as a fresh 0->1 transition:
  - sw_clean rises STABLE_CYCLES+1 edges after the first post-reset sampling edge.
  - sw_rise pulses once at that point.
- STABLE_CYCLES == 1: there is no filtering beyond the synchronizer. sw_clean follows s2 one edge later.

Decomposition:
- Shared package sw_pkg holds:
  - DEBOUNCE_10MS_100MHZ = 1000000
  - DEBOUNCE_SIM = 4, for benches
- Sub-module debounce_bit (single-bit synchronizer + counter + pulse regs, same parameters minus WIDTH). switch_debounce instantiates it WIDTH times in a generate loop and contains no other logic.

Test Plan (all scenarios use STABLE_CYCLES=4, WIDTH=2):
- Reset: hold reset with sw_raw=2'b11 -> sw_clean=00, rise=00, fall=00 throughout. Release reset, first sampling edge E -> sw_clean=11 after edge E+5; sw_rise=11 for exactly one cycle.
- Clean step: sw_raw 00->01 sampled at edge N -> sw_clean=01 after edge N+5; sw_rise=01 for one cycle. Then sw_raw 01->00 -> sw_clean=00 after 5 edges; sw_fall=01 for one cycle.
- Bounce reject: sw_raw[1] toggles high for 3 cycles then low, repeated 5 times -> sw_clean[1] stays 0; sw_rise[1] never asserts.
- Bounce then settle: sw_raw[0] bounces 1,0,1,0, then stays 1 -> sw_clean[0] rises exactly 5 edges after the last 0->1 sampling edge; exactly one sw_rise[0] pulse.
- Simultaneous: sw_raw 00->11 on one edge -> both sw_clean bits rise on the same edge; sw_rise=11 for one cycle.
- Reset mid-count: sw_raw 00->10, assert reset asynchronously (mid-cycle) after 2 edges, release after 3 cycles with sw_raw still 10 -> sw_clean=00 immediately on assert; sw_clean=10 after 5 edges from the first post-reset sampling edge; sw_rise=10 once; no stray pulses.
